// File: rtl/sram_initiator.sv
// Core-side request port to ext_sram stb/ack bridge: a 2-entry request FIFO
// feeds a two-state issue FSM with an optional ack timeout.
module sram_initiator #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_stb,
  output logic        o_rw,
  output logic [31:0] o_addr,
  output logic [31:0] o_dtw,
  input  logic        i_ack,
  input  logic [31:0] i_dtr
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam bit          TIMEOUT_ON   = (TIMEOUT_CYC != 0);

  state_t      r_state;
  state_t      w_stateNxt;

  logic        r_fifoRw   [2];
  logic [31:0] r_fifoAddr [2];
  logic [31:0] r_fifoData [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;

  logic        r_stb;
  logic        r_rw;
  logic [31:0] r_addr;
  logic [31:0] r_dtw;
  logic        r_rspValid;
  logic        r_rspErr;
  logic [31:0] r_rspData;
  logic [15:0] r_tCnt;

  logic        w_push;
  logic        w_pop;
  logic        w_ackHit;
  logic        w_timeout;

  logic        w_stbNxt;
  logic        w_rwNxt;
  logic [31:0] w_addrNxt;
  logic [31:0] w_dtwNxt;
  logic        w_rspValidNxt;
  logic        w_rspErrNxt;
  logic [31:0] w_rspDataNxt;
  logic [15:0] w_tCntNxt;

  // Ready comes from the registered count only, so a pop while full frees space next cycle.
  assign req_ready = (r_count != 2'd2);
  assign w_push    = req_valid & req_ready;
  assign w_pop     = (r_state == IDLE) & (r_count != 2'd0);
  assign w_ackHit  = (r_state == BUS) & i_ack;
  assign w_timeout = (r_state == BUS) & ~i_ack & TIMEOUT_ON & (r_tCnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifoRw[i]   <= 1'b0;
        r_fifoAddr[i] <= 32'd0;
        r_fifoData[i] <= 32'd0;
      end
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifoRw[r_wrPtr]   <= req_rw;
        r_fifoAddr[r_wrPtr] <= req_addr;
        r_fifoData[r_wrPtr] <= req_data;
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      IDLE:    if (r_count != 2'd0) w_stateNxt = BUS;
      BUS:     if (w_ackHit || w_timeout) w_stateNxt = IDLE;
      default: w_stateNxt = IDLE;
    endcase
  end

  always_comb begin
    w_stbNxt      = r_stb;
    w_rwNxt       = r_rw;
    w_addrNxt     = r_addr;
    w_dtwNxt      = r_dtw;
    w_rspValidNxt = 1'b0;
    w_rspErrNxt   = r_rspErr;
    w_rspDataNxt  = r_rspData;
    w_tCntNxt     = r_tCnt;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_stbNxt  = 1'b1;
          w_rwNxt   = r_fifoRw[r_rdPtr];
          w_addrNxt = r_fifoAddr[r_rdPtr];
          w_dtwNxt  = r_fifoData[r_rdPtr];
          w_tCntNxt = 16'd0;
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the timeout edge completes without error.
        if (w_ackHit) begin
          w_stbNxt      = 1'b0;
          w_rspValidNxt = 1'b1;
          w_rspErrNxt   = 1'b0;
          w_rspDataNxt  = r_rw ? 32'd0 : i_dtr;
        end else if (w_timeout) begin
          w_stbNxt      = 1'b0;
          w_rspValidNxt = 1'b1;
          w_rspErrNxt   = 1'b1;
          w_rspDataNxt  = 32'd0;
        end else if (r_tCnt != 16'hFFFF) begin
          w_tCntNxt = r_tCnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stb      <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= 32'd0;
      r_dtw      <= 32'd0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspData  <= 32'd0;
      r_tCnt     <= 16'd0;
    end else begin
      r_stb      <= w_stbNxt;
      r_rw       <= w_rwNxt;
      r_addr     <= w_addrNxt;
      r_dtw      <= w_dtwNxt;
      r_rspValid <= w_rspValidNxt;
      r_rspErr   <= w_rspErrNxt;
      r_rspData  <= w_rspDataNxt;
      r_tCnt     <= w_tCntNxt;
    end
  end

  assign o_stb     = r_stb;
  assign o_rw      = r_rw;
  assign o_addr    = r_addr;
  assign o_dtw     = r_dtw;
  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_data  = r_rspData;
  assign busy      = (r_count != 2'd0) | (r_state != IDLE);

endmodule

// File: tb/tb_sram_initiator.sv
// Scoreboard bench for sram_initiator: one instance with a 4-cycle timeout,
// one with timeout disabled, selected onto shared stimulus/observation nets.
module tb_sram_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        i_ack;
  logic [31:0] i_dtr;

  logic        a_reqReady, a_rspValid, a_rspErr, a_busy, a_stb, a_rw;
  logic [31:0] a_rspData, a_addr, a_dtw;
  logic        b_reqReady, b_rspValid, b_rspErr, b_busy, b_stb, b_rw;
  logic [31:0] b_rspData, b_addr, b_dtw;

  logic        cur_reqReady, cur_rspValid, cur_rspErr, cur_busy, cur_stb, cur_rw;
  logic [31:0] cur_rspData, cur_addr, cur_dtw;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_initiator #(.TIMEOUT_CYC(4)) dutA (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(a_reqReady),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(a_rspValid), .rsp_data(a_rspData), .rsp_err(a_rspErr),
    .busy(a_busy), .o_stb(a_stb), .o_rw(a_rw), .o_addr(a_addr), .o_dtw(a_dtw),
    .i_ack(i_ack & ~sel), .i_dtr(i_dtr)
  );

  sram_initiator #(.TIMEOUT_CYC(0)) dutB (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(b_reqReady),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(b_rspValid), .rsp_data(b_rspData), .rsp_err(b_rspErr),
    .busy(b_busy), .o_stb(b_stb), .o_rw(b_rw), .o_addr(b_addr), .o_dtw(b_dtw),
    .i_ack(i_ack & sel), .i_dtr(i_dtr)
  );

  assign cur_reqReady = sel ? b_reqReady : a_reqReady;
  assign cur_rspValid = sel ? b_rspValid : a_rspValid;
  assign cur_rspErr   = sel ? b_rspErr   : a_rspErr;
  assign cur_rspData  = sel ? b_rspData  : a_rspData;
  assign cur_busy     = sel ? b_busy     : a_busy;
  assign cur_stb      = sel ? b_stb      : a_stb;
  assign cur_rw       = sel ? b_rw       : a_rw;
  assign cur_addr     = sel ? b_addr     : a_addr;
  assign cur_dtw      = sel ? b_dtw      : a_dtw;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    logic rdy;
    bit   done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_data  = data;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = cur_reqReady;
      tick();
      if (rdy) done = 1'b1;
    end
    req_valid = 1'b0;
    checkOutput("req_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic waitStb(input int maxCyc);
    for (int i = 0; i < maxCyc && !cur_stb; i++) tick();
    checkOutput("stb_rise", {31'd0, cur_stb}, 32'd1);
  endtask

  task automatic expectRsp(input logic [31:0] data, input logic err);
    rsp_t e;
    e.data = data;
    e.err  = err;
    expQ.push_back(e);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && cur_rspValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 data=%h err=%b, expected no response at %0t",
                 cur_rspData, cur_rspErr, $time);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_data", cur_rspData, e.data);
        checkOutput("rsp_err", {31'd0, cur_rspErr}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fa [4];
    int          n;
    int          acc;
    int          guard;
    int          issued;
    int          lowRun;
    logic        rdy;
    logic        accNow;

    fa[0] = 32'h0; fa[1] = 32'h4; fa[2] = 32'h8; fa[3] = 32'hC;
    reset = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_data = 32'd0;
    i_ack = 1'b0; i_dtr = 32'd0;

    #12;
    checkOutput("rst_stb",   {31'd0, cur_stb},      32'd0);
    checkOutput("rst_ready", {31'd0, cur_reqReady}, 32'd1);
    checkOutput("rst_busy",  {31'd0, cur_busy},     32'd0);
    checkOutput("rst_rspv",  {31'd0, cur_rspValid}, 32'd0);
    checkOutput("rst_addr",  cur_addr,              32'd0);
    checkOutput("rst_dtw",   cur_dtw,               32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single read, ack driven two cycles after the strobe rises.
    applyStimulus(1'b0, 32'hAAAA_AAA0, 32'd0);
    checkOutput("rd_stb_latency", {31'd0, cur_stb}, 32'd0);
    tick();
    expectRsp(32'hABCD_1234, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      checkOutput("rd_stb_high", {31'd0, cur_stb}, 32'd1);
      checkOutput("rd_addr", cur_addr, 32'hAAAA_AAA0);
      if (c == 3) begin
        i_ack = 1'b1;
        i_dtr = 32'hABCD_1234;
      end
      tick();
    end
    i_ack = 1'b0;
    checkOutput("rd_stb_fall", {31'd0, cur_stb}, 32'd0);
    checkOutput("rd_rsp_pulse", {31'd0, cur_rspValid}, 32'd1);
    tick();
    checkOutput("rd_rsp_one_cycle", {31'd0, cur_rspValid}, 32'd0);

    // Single write with an ack in the first strobe cycle.
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_stb", {31'd0, cur_stb}, 32'd1);
    checkOutput("wr_rw",  {31'd0, cur_rw},  32'd1);
    checkOutput("wr_dtw", cur_dtw, 32'hDEAD_BEEF);
    checkOutput("wr_addr", cur_addr, 32'h0000_0010);
    expectRsp(32'd0, 1'b0);
    i_ack = 1'b1;
    i_dtr = 32'h5555_5555;
    tick();
    i_ack = 1'b0;
    checkOutput("wr_stb_fall", {31'd0, cur_stb}, 32'd0);
    tick();

    // Timeout after four strobe cycles.
    applyStimulus(1'b0, 32'h0000_0040, 32'd0);
    expectRsp(32'd0, 1'b1);
    waitStb(5);
    n = 0;
    while (cur_stb && n < 20) begin
      n++;
      tick();
    end
    checkOutput("to_stb_cycles", 32'(n), 32'd4);
    checkOutput("to_rsp_with_fall", {31'd0, cur_rspValid}, 32'd1);
    checkOutput("to_err", {31'd0, cur_rspErr}, 32'd1);
    tick();

    // Ack arriving on the timeout edge completes without error.
    applyStimulus(1'b0, 32'h0000_0080, 32'd0);
    tick();
    expectRsp(32'h1357_9BDF, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      checkOutput("col_stb_high", {31'd0, cur_stb}, 32'd1);
      if (s == 4) begin
        i_ack = 1'b1;
        i_dtr = 32'h1357_9BDF;
      end
      tick();
    end
    i_ack = 1'b0;
    checkOutput("col_stb_fall", {31'd0, cur_stb}, 32'd0);
    checkOutput("col_err", {31'd0, cur_rspErr}, 32'd0);
    tick();

    // Stray ack while idle.
    for (int s = 0; s < 3; s++) begin
      i_ack = 1'b1;
      i_dtr = 32'hFFFF_FFFF;
      tick();
      checkOutput("stray_rspv", {31'd0, cur_rspValid}, 32'd0);
      checkOutput("stray_stb",  {31'd0, cur_stb},      32'd0);
    end
    i_ack = 1'b0;
    tick();
    checkOutput("stray_busy", {31'd0, cur_busy}, 32'd0);

    // Remaining scenarios run on the instance without a timeout.
    sel = 1'b1;
    tick();

    // FIFO full: three accepts fill it (one in flight, two queued).
    req_valid = 1'b1; req_rw = 1'b0; req_data = 32'd0;
    acc = 0; guard = 0;
    while (acc < 3 && guard < 10) begin
      req_addr = fa[acc];
      rdy = cur_reqReady;
      tick();
      if (rdy) acc++;
      guard++;
    end
    req_addr = fa[3];
    checkOutput("full_accepts", 32'(acc), 32'd3);
    checkOutput("full_ready_low", {31'd0, cur_reqReady}, 32'd0);
    tick();
    tick();
    checkOutput("full_ready_held", {31'd0, cur_reqReady}, 32'd0);
    checkOutput("full_first_addr", cur_addr, 32'h0);

    issued = 0; lowRun = 0; guard = 0;
    while ((issued < 4 || cur_stb || i_ack) && guard < 100) begin
      accNow = req_valid && cur_reqReady;
      if (i_ack) begin
        i_ack = 1'b0;
      end else if (cur_stb) begin
        checkOutput("fifo_order", cur_addr, fa[issued]);
        if (issued > 0) checkOutput("fifo_gap", 32'(lowRun), 32'd1);
        i_ack = 1'b1;
        i_dtr = 32'h1000_0000 | fa[issued];
        expectRsp(32'h1000_0000 | fa[issued], 1'b0);
        issued++;
        lowRun = 0;
      end
      if (!cur_stb) lowRun++;
      tick();
      guard++;
      if (accNow) req_valid = 1'b0;
    end
    checkOutput("fifo_issued", 32'(issued), 32'd4);
    tick();
    tick();
    checkOutput("fifo_drained_busy", {31'd0, cur_busy}, 32'd0);
    checkOutput("fifo_drained_ready", {31'd0, cur_reqReady}, 32'd1);

    // Timeout disabled: strobe holds indefinitely with no response.
    applyStimulus(1'b0, 32'h0000_0200, 32'd0);
    waitStb(3);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cur_stb) n++;
      tick();
    end
    checkOutput("no_to_stb_cycles", 32'(n), 32'd1000);
    expectRsp(32'h2468_ACE0, 1'b0);
    i_ack = 1'b1;
    i_dtr = 32'h2468_ACE0;
    tick();
    i_ack = 1'b0;
    checkOutput("no_to_stb_fall", {31'd0, cur_stb}, 32'd0);
    tick();

    // Asynchronous reset with one request in flight and one queued.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h300;
    tick();
    req_addr = 32'h304;
    tick();
    req_valid = 1'b0;
    checkOutput("mid_stb",  {31'd0, cur_stb},  32'd1);
    checkOutput("mid_busy", {31'd0, cur_busy}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst_stb",   {31'd0, cur_stb},      32'd0);
    checkOutput("arst_busy",  {31'd0, cur_busy},     32'd0);
    checkOutput("arst_ready", {31'd0, cur_reqReady}, 32'd1);
    #2;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cur_stb || cur_rspValid) n++;
    end
    checkOutput("post_rst_quiet", 32'(n), 32'd0);
    checkOutput("post_rst_busy", {31'd0, cur_busy}, 32'd0);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
